pipe_fetch_stage: RTL and testbench
===================================

Name: pipe_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS CPU.
- Owns the PC register and drives the instruction-memory address combinationally.
- Selects the next PC from sequential, redirect or pending-redirect sources.
- Registers the fetched word into the IF/ID pipeline register feeding decode, with stall hold and a pending-redirect state machine for redirects arriving during stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID for a bubble (sll $0,$0,0).
- DELAY_SLOT, 1, 1 = instruction in IF at redirect is the delay slot and is kept; 0 = it is squashed to a bubble.

Ports:
- clock  input  1  rising-edge clock for all state.
- resetn  input  1  synchronous active-low reset.
- stall  input  1  hazard stall from decode; hold PC and IF/ID.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC for a taken branch/jump.
- imem_addr  output  32  instruction-memory address, equal to the PC register.
- imem_inst  input  32  instruction word returned combinationally by instruction memory.
- id_pc  output  32  PC of the instruction held in IF/ID.
- id_pc4  output  32  id_pc + 4.
- id_inst  output  32  instruction held in IF/ID.
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clock, resetn). All state updates on the rising edge of clock.
- Reset (resetn=0 at an edge):
  - pc=RESET_PC, id_pc=0, id_pc4=0, id_inst=NOP_INST, id_valid=0.
  - State=RUN, pending_target=0.
  - Overrides stall and redirect.
  - A reset during HOLD_REDIR discards the pending target.
- imem_addr = pc, combinational, zero latency. imem_inst is sampled in the same cycle.
- pc4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- redirect_target[1:0] is forced to 2'b00 before use.
- States: RUN, HOLD_REDIR.
- RUN, stall=0, redirect_valid=0:
  - pc <= pc4.
  - IF/ID <= {pc, pc4, imem_inst}, id_valid <= 1.
- RUN, stall=0, redirect_valid=1:
  - pc <= target.
  - IF/ID captures the current fetch if DELAY_SLOT=1.
  - If DELAY_SLOT=0, IF/ID gets pc, pc4, NOP_INST and id_valid=0.
- RUN, stall=1, redirect_valid=0: pc and IF/ID hold.
- RUN, stall=1, redirect_valid=1:
  - pc and IF/ID hold.
  - pending_target <= target; go to HOLD_REDIR.
- HOLD_REDIR, stall=1:
  - pc and IF/ID hold.
  - A new redirect_valid overwrites pending_target (latest wins).
- HOLD_REDIR, stall=0:
  - pc <= (redirect_valid ? target : pending_target); a redirect in the release cycle wins.
  - IF/ID takes the current fetch, or a bubble, per DELAY_SLOT exactly as in RUN.
  - Go to RUN.
- Latency: an instruction at pc appears on id_inst one edge after its fetch cycle with stall=0.
- A redirect takes effect on imem_addr in the cycle after the edge that accepts it.
- No output is combinationally dependent on stall or redirect except via registers.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra outputs:
  - fetch_count[31:0]: increments on each edge where IF/ID loads with id_valid<=1.
  - stall_count[31:0]: increments on each edge with stall=1.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with imem returning 32'h2001_0005 at address 0, then release resetn with stall=0 -> imem_addr sequence 0,4,8,12. After the first edge, id_pc=0, id_pc4=4, id_inst=32'h2001_0005, id_valid=1.
- Redirect at pc=8 with target 32'h40, DELAY_SLOT=1 -> next imem_addr=32'h40; id_pc=8 with valid=1 (delay slot kept). With DELAY_SLOT=0, id_valid=0 and id_inst=NOP_INST.
- Stall=1 for 3 cycles at pc=12 -> imem_addr stays 12 and IF/ID unchanged. On release, id_pc=12 and the next imem_addr=16.
- Stalled redirect at pc=20: target 32'h80, then 32'h100 while still stalled; release stall -> imem_addr=32'h100 on the cycle after release; state returns to RUN.
- Redirect to 32'h83 -> imem_addr=32'h80. Run pc from 32'hFFFF_FFF8 -> imem_addr wraps to 32'hFFFF_FFFC, then 0.
- Assert resetn=0 while in HOLD_REDIR with a pending target -> pc=RESET_PC and id_valid=0. After release, fetch proceeds sequentially with no stale redirect. With FETCH_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register with stall hold.
// Optional FETCH_PERF_CNT_EN macro adds fetch_count/stall_count performance counters.
module pipe_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    // state      | meaning
    // RUN        | normal fetch, no redirect outstanding
    // HOLD_REDIR | redirect accepted during a stall, waiting for release
    typedef enum logic [0:0] {
        RUN        = 1'b0,
        HOLD_REDIR = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending_target;
    logic [31:0] pc4;
    logic [31:0] target;
    logic        redirecting;
    logic        bubble;

    always_comb begin
        pc4         = pc + 32'd4;
        target      = {redirect_target[31:2], 2'b00};
        redirecting = redirect_valid || (state == HOLD_REDIR);
        bubble      = (DELAY_SLOT == 0) && redirecting;
    end

    assign imem_addr = pc;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state          <= RUN;
            pc             <= RESET_PC;
            pending_target <= 32'h0000_0000;
            id_pc          <= 32'h0000_0000;
            id_pc4         <= 32'h0000_0000;
            id_inst        <= NOP_INST;
            id_valid       <= 1'b0;
        end else if (stall) begin
            // Hold PC and IF/ID; remember the latest redirect seen while stalled.
            if (redirect_valid) begin
                pending_target <= target;
                state          <= HOLD_REDIR;
            end
        end else begin
            if (redirect_valid)
                pc <= target;
            else if (state == HOLD_REDIR)
                pc <= pending_target;
            else
                pc <= pc4;

            id_pc  <= pc;
            id_pc4 <= pc4;
            if (bubble) begin
                id_inst  <= NOP_INST;
                id_valid <= 1'b0;
            end else begin
                id_inst  <= imem_inst;
                id_valid <= 1'b1;
            end
            state <= RUN;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (!resetn) begin
            fetch_count <= 32'h0000_0000;
            stall_count <= 32'h0000_0000;
        end else begin
            if (!stall && !bubble)
                fetch_count <= fetch_count + 32'd1;
            if (stall)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Directed bench for pipe_fetch_stage: one DUT with the delay slot kept, one with it squashed.
// Both share stimulus; a behavioural instruction memory answers each DUT's address.
module tb_pipe_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clock;
    logic        resetn;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    logic [31:0] imem_addr, imem_inst, id_pc, id_pc4, id_inst;
    logic        id_valid;
    logic [31:0] imem_addr0, imem_inst0, id_pc0, id_pc40, id_inst0;
    logic        id_valid0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count, fetch_count0, stall_count0;
`endif

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2001_0005 : (a ^ 32'h1234_0000);
    endfunction

    assign imem_inst  = mem(imem_addr);
    assign imem_inst0 = mem(imem_addr0);

    pipe_fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP), .DELAY_SLOT(1)) dut (
        .clock(clock), .resetn(resetn), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_inst(imem_inst),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst), .id_valid(id_valid)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    pipe_fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP), .DELAY_SLOT(0)) dut0 (
        .clock(clock), .resetn(resetn), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr0), .imem_inst(imem_inst0),
        .id_pc(id_pc0), .id_pc4(id_pc40), .id_inst(id_inst0), .id_valid(id_valid0)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count0), .stall_count(stall_count0)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        step(); step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", id_valid); end
        checks++; if (id_inst !== NOP) begin errors++; $display("FAIL rst_inst: got %h expected %h", id_inst, NOP); end
        checks++; if (id_pc !== 32'h0 || id_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h/%h expected 0/0", id_pc, id_pc4); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h/%h expected 0/0", fetch_count, stall_count); end
`endif
    endtask

    task automatic test_sequential();
        resetn = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr1: got %h expected 4", imem_addr); end
        checks++; if (id_pc !== 32'h0 || id_pc4 !== 32'h4) begin errors++; $display("FAIL seq_pc1: got %h/%h expected 0/4", id_pc, id_pc4); end
        checks++; if (id_inst !== 32'h2001_0005 || id_valid !== 1'b1) begin errors++; $display("FAIL seq_inst1: got %h/%b expected 20010005/1", id_inst, id_valid); end
        step();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr2: got %h expected 8", imem_addr); end
        checks++; if (id_pc !== 32'h4 || id_inst !== 32'h1234_0004) begin errors++; $display("FAIL seq_inst2: got %h/%h expected 4/12340004", id_pc, id_inst); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_target = 32'h40;
        step();
        checks++; if (imem_addr !== 32'h40 || imem_addr0 !== 32'h40) begin errors++; $display("FAIL redir_addr: got %h/%h expected 40", imem_addr, imem_addr0); end
        checks++; if (id_pc !== 32'h8 || id_inst !== 32'h1234_0008 || id_valid !== 1'b1) begin errors++; $display("FAIL redir_ds1: got %h/%h/%b expected 8/12340008/1", id_pc, id_inst, id_valid); end
        checks++; if (id_pc0 !== 32'h8 || id_pc40 !== 32'hC || id_inst0 !== NOP || id_valid0 !== 1'b0) begin errors++; $display("FAIL redir_ds0: got %h/%h/%h/%b expected 8/c/0/0", id_pc0, id_pc40, id_inst0, id_valid0); end
        redirect_target = 32'hC;
        step();
        redirect_valid = 1'b0;
        chk32("redir_to_c", imem_addr, 32'hC);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (imem_addr !== 32'hC || id_pc !== 32'h40 || id_inst !== 32'h1234_0040) begin errors++; $display("FAIL stall_hold%0d: got %h/%h/%h expected c/40/12340040", i, imem_addr, id_pc, id_inst); end
        end
        stall = 1'b0;
        step();
        checks++; if (id_pc !== 32'hC || imem_addr !== 32'h10 || id_valid !== 1'b1) begin errors++; $display("FAIL stall_release: got %h/%h/%b expected c/10/1", id_pc, imem_addr, id_valid); end
        step();
        chk32("stall_next", imem_addr, 32'h14);
    endtask

    task automatic test_stalled_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
        step();
        checks++; if (imem_addr !== 32'h14 || id_pc !== 32'h10) begin errors++; $display("FAIL sredir_hold1: got %h/%h expected 14/10", imem_addr, id_pc); end
        redirect_target = 32'h100;
        step();
        redirect_valid = 1'b0;
        step();
        chk32("sredir_hold3", imem_addr, 32'h14);
        stall = 1'b0;
        step();
        checks++; if (imem_addr !== 32'h100 || id_pc !== 32'h14 || id_valid !== 1'b1) begin errors++; $display("FAIL sredir_release: got %h/%h/%b expected 100/14/1", imem_addr, id_pc, id_valid); end
        checks++; if (id_valid0 !== 1'b0 || id_inst0 !== NOP) begin errors++; $display("FAIL sredir_ds0: got %b/%h expected 0/0", id_valid0, id_inst0); end
        step();
        checks++; if (imem_addr !== 32'h104 || id_pc !== 32'h100 || id_valid0 !== 1'b1) begin errors++; $display("FAIL sredir_run: got %h/%h/%b expected 104/100/1", imem_addr, id_pc, id_valid0); end
        // A redirect in the release cycle beats the pending target.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
        step();
        stall = 1'b0; redirect_target = 32'h300;
        step();
        redirect_valid = 1'b0;
        chk32("sredir_release_wins", imem_addr, 32'h300);
    endtask

    task automatic test_align_wrap();
        redirect_valid = 1'b1; redirect_target = 32'h83;
        step();
        chk32("align", imem_addr, 32'h80);
        redirect_target = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        chk32("wrap_start", imem_addr, 32'hFFFF_FFF8);
        step();
        checks++; if (imem_addr !== 32'hFFFF_FFFC || id_pc4 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fffc: got %h/%h expected fffffffc/fffffffc", imem_addr, id_pc4); end
        step();
        checks++; if (imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h/%h/%h expected 0/fffffffc/0", imem_addr, id_pc, id_pc4); end
    endtask

    task automatic test_reset_in_hold();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h500;
        step();
        redirect_valid = 1'b0;
        resetn = 1'b0;
        step();
        checks++; if (imem_addr !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("FAIL hold_rst: got %h/%b expected 0/0", imem_addr, id_valid); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin errors++; $display("FAIL hold_rst_cnt: got %h/%h expected 0/0", fetch_count, stall_count); end
`endif
        resetn = 1'b1; stall = 1'b0;
        step();
        checks++; if (imem_addr !== 32'h4 || id_pc !== 32'h0 || id_valid !== 1'b1 || id_valid0 !== 1'b1) begin errors++; $display("FAIL post_rst1: got %h/%h/%b/%b expected 4/0/1/1", imem_addr, id_pc, id_valid, id_valid0); end
        step();
        chk32("post_rst2", imem_addr, 32'h8);
`ifdef FETCH_PERF_CNT_EN
        stall = 1'b1;
        step();
        stall = 1'b0;
        checks++; if (fetch_count !== 32'd2 || stall_count !== 32'd1) begin errors++; $display("FAIL perf_cnt: got %0d/%0d expected 2/1", fetch_count, stall_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_stalled_redirect();
        test_align_wrap();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
